// File: rtl/systolic_result_streamer.sv
// Captures one flat NxN result frame from the systolic array and streams it
// out row-major, one element per valid/ready handshake, with row/col tags.
module systolic_result_streamer #(
  parameter int ARRAY_SIZE = 2,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8,
  localparam int NN = ARRAY_SIZE * ARRAY_SIZE,
  localparam int RW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1,
  localparam int IW = (NN > 1) ? $clog2(NN) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH*NN-1:0]   in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [RW-1:0]              out_row,
  output logic [RW-1:0]              out_col,
  output logic                       out_last_col,
  output logic                       out_last,
  output logic                       overrun,
  input  logic                       clr_overrun,
  output logic [CNT_WIDTH-1:0]       frames_done
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                             state;
  logic [IW-1:0]                      idx_p0;
  logic [NN-1:0][DATA_WIDTH-1:0]      frame_p0;
  logic                               idx_last;
  logic [RW-1:0]                      row_w;
  logic [RW-1:0]                      col_w;

  assign idx_last  = (idx_p0 == IW'(NN - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == STREAM);

  always_comb begin
    row_w = RW'(32'(idx_p0) / 32'(ARRAY_SIZE));
    col_w = RW'(32'(idx_p0) % 32'(ARRAY_SIZE));
  end

  // Capture stage: frame register, element index and bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx_p0      <= '0;
      frame_p0    <= '0;
      overrun     <= 1'b0;
      frames_done <= '0;
    end else begin
      // A frame offered while busy is dropped; a new drop beats a clear.
      if (in_valid && state != IDLE)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (in_valid) begin
            frame_p0 <= in_data;
            idx_p0   <= '0;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (idx_last) begin
              idx_p0      <= '0;
              state       <= IDLE;
              frames_done <= frames_done + CNT_WIDTH'(1);
            end else begin
              idx_p0 <= idx_p0 + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: element and tags decoded from the held index, zero when idle
  always_comb begin
    out_data     = '0;
    out_row      = '0;
    out_col      = '0;
    out_last_col = 1'b0;
    out_last     = 1'b0;
    if (state == STREAM) begin
      out_data     = frame_p0[idx_p0];
      out_row      = row_w;
      out_col      = col_w;
      out_last_col = (col_w == RW'(ARRAY_SIZE - 1));
      out_last     = idx_last;
    end
  end

endmodule

// File: tb/tb_systolic_result_streamer.sv
// Directed bench for systolic_result_streamer: table of per-cycle vectors plus
// hand-written reset-mid-stream and frame-counter wrap sequences.
module tb_systolic_result_streamer;

  localparam logic [63:0] ID_F = 64'h0400_0000_0000_0400;
  localparam logic [63:0] BP_F = 64'h0004_0003_0002_0001;
  localparam logic [63:0] FF_F = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_row;
  logic        out_col;
  logic        out_last_col;
  logic        out_last;
  logic        overrun;
  logic        clr_overrun;
  logic [7:0]  frames_done;

  int n_checks = 0;
  int n_fail   = 0;

  systolic_result_streamer #(.ARRAY_SIZE(2), .DATA_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last_col(out_last_col),
    .out_last(out_last), .overrun(overrun), .clr_overrun(clr_overrun),
    .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [63:0] id;
    logic        ordy;
    logic        clr;
    logic        ev;
    logic [15:0] ed;
    logic        er;
    logic        ec;
    logic        elc;
    logic        el;
    logic        erdy;
    logic        eovr;
    logic [7:0]  efd;
  } vec_t;

  vec_t vt[21];

  function automatic vec_t mk(input logic iv, input logic [63:0] id, input logic ordy,
                              input logic clr, input logic ev, input logic [15:0] ed,
                              input logic er, input logic ec, input logic elc, input logic el,
                              input logic erdy, input logic eovr, input logic [7:0] efd);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.clr = clr; v.ev = ev; v.ed = ed;
    v.er = er; v.ec = ec; v.elc = elc; v.el = el; v.erdy = erdy; v.eovr = eovr;
    v.efd = efd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " out_valid"},    64'(out_valid),    64'(v.ev));
    chk({tag, " out_data"},     64'(out_data),     64'(v.ed));
    chk({tag, " out_row"},      64'(out_row),      64'(v.er));
    chk({tag, " out_col"},      64'(out_col),      64'(v.ec));
    chk({tag, " out_last_col"}, 64'(out_last_col), 64'(v.elc));
    chk({tag, " out_last"},     64'(out_last),     64'(v.el));
    chk({tag, " in_ready"},     64'(in_ready),     64'(v.erdy));
    chk({tag, " overrun"},      64'(overrun),      64'(v.eovr));
    chk({tag, " frames_done"},  64'(frames_done),  64'(v.efd));
  endtask

  initial begin
    int n_cap;
    int last_cap;
    int cyc;

    //         iv  in_data ordy clr  ev  data     r  c  lc l  rdy ovr fd
    vt[0]  = mk(1, ID_F,    1,  0,   0, 16'h0000, 0, 0, 0, 0, 1,  0,  0);
    vt[1]  = mk(0, 64'h0,   1,  0,   1, 16'h0400, 0, 0, 0, 0, 0,  0,  0);
    vt[2]  = mk(0, 64'h0,   1,  0,   1, 16'h0000, 0, 1, 1, 0, 0,  0,  0);
    vt[3]  = mk(0, 64'h0,   1,  0,   1, 16'h0000, 1, 0, 0, 0, 0,  0,  0);
    vt[4]  = mk(0, 64'h0,   1,  0,   1, 16'h0400, 1, 1, 1, 1, 0,  0,  0);
    vt[5]  = mk(1, BP_F,    1,  0,   0, 16'h0000, 0, 0, 0, 0, 1,  0,  1);
    vt[6]  = mk(0, 64'h0,   1,  0,   1, 16'h0001, 0, 0, 0, 0, 0,  0,  1);
    vt[7]  = mk(0, 64'h0,   0,  0,   1, 16'h0002, 0, 1, 1, 0, 0,  0,  1);
    vt[8]  = mk(0, 64'h0,   0,  0,   1, 16'h0002, 0, 1, 1, 0, 0,  0,  1);
    vt[9]  = mk(0, 64'h0,   1,  0,   1, 16'h0002, 0, 1, 1, 0, 0,  0,  1);
    vt[10] = mk(0, 64'h0,   0,  0,   1, 16'h0003, 1, 0, 0, 0, 0,  0,  1);
    vt[11] = mk(0, 64'h0,   1,  0,   1, 16'h0003, 1, 0, 0, 0, 0,  0,  1);
    vt[12] = mk(0, 64'h0,   1,  0,   1, 16'h0004, 1, 1, 1, 1, 0,  0,  1);
    vt[13] = mk(1, BP_F,    1,  0,   0, 16'h0000, 0, 0, 0, 0, 1,  0,  2);
    vt[14] = mk(1, FF_F,    1,  0,   1, 16'h0001, 0, 0, 0, 0, 0,  0,  2);
    vt[15] = mk(1, FF_F,    0,  1,   1, 16'h0002, 0, 1, 1, 0, 0,  1,  2);
    vt[16] = mk(0, 64'h0,   0,  1,   1, 16'h0002, 0, 1, 1, 0, 0,  1,  2);
    vt[17] = mk(0, 64'h0,   1,  0,   1, 16'h0002, 0, 1, 1, 0, 0,  0,  2);
    vt[18] = mk(0, 64'h0,   1,  0,   1, 16'h0003, 1, 0, 0, 0, 0,  0,  2);
    vt[19] = mk(0, 64'h0,   1,  0,   1, 16'h0004, 1, 1, 1, 1, 0,  0,  2);
    vt[20] = mk(0, 64'h0,   1,  0,   0, 16'h0000, 0, 0, 0, 0, 1,  0,  3);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_overrun = 1'b0;
    @(negedge clk);
    chk("reset out_valid",   64'(out_valid),   64'd0);
    chk("reset in_ready",    64'(in_ready),    64'd1);
    chk("reset frames_done", 64'(frames_done), 64'd0);
    chk("reset overrun",     64'(overrun),     64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Identity, backpressure and overrun vectors: check then drive, once per cycle
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vt[i]);
      in_valid    = vt[i].iv;
      in_data     = vt[i].id;
      out_ready   = vt[i].ordy;
      clr_overrun = vt[i].clr;
    end

    // Reset in the middle of a frame after two accepted elements
    @(negedge clk);
    in_valid = 1'b1; in_data = BP_F; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst pre data", 64'(out_data), 64'h0003);
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid",   64'(out_valid),   64'd0);
    chk("midrst in_ready",    64'(in_ready),    64'd1);
    chk("midrst frames_done", 64'(frames_done), 64'd0);
    chk("midrst out_row",     64'(out_row),     64'd0);
    chk("midrst out_col",     64'(out_col),     64'd0);
    chk("midrst out_data",    64'(out_data),    64'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_data = ID_F;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post-rst out_valid", 64'(out_valid), 64'd1);
    chk("post-rst out_data",  64'(out_data),  64'h0400);
    chk("post-rst out_row",   64'(out_row),   64'd0);
    chk("post-rst out_col",   64'(out_col),   64'd0);
    repeat (4) @(negedge clk);
    chk("post-rst frames_done", 64'(frames_done), 64'd1);

    // Counter wrap: 257 frames back-to-back at full rate
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    n_cap = 0; last_cap = 0; cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      if (in_ready) begin
        if (n_cap == 255 || n_cap == 256 || n_cap == 257)
          chk($sformatf("wrap fd after %0d", n_cap), 64'(frames_done), 64'(n_cap % 256));
        if (n_cap == 257) break;
        if (n_cap > 0)
          chk($sformatf("wrap period %0d", n_cap), 64'(cyc - last_cap), 64'd5);
        in_valid = 1'b1; in_data = BP_F;
        last_cap = cyc;
        n_cap++;
      end else begin
        in_valid = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("wrap reached 257 frames", 64'(n_cap), 64'd257);
    chk("wrap no overrun", 64'(overrun), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_result_streamer.md
Name: systolic_result_streamer

Overview:
- Unload side of systolic_array_top: captures one flat NxN result frame (result_flat, qualified by result_valid) and streams it out one element per handshake.
- Order is row-major, over a valid/ready interface, tagged with row/col indices and end-of-row/end-of-frame markers.
- Sits between the array and downstream consumers (e.g. activation unit, writeback).
- Flags frames that arrive while streaming as overruns and drops them.

Parameters:
- ARRAY_SIZE, 2: matrix dimension N; N*N elements per frame.
- DATA_WIDTH, 16: element width (Q5.10 result format; 1.0 = 16'h0400).
- CNT_WIDTH, 8: width of the completed-frame counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  frame valid; connects to result_valid.
- in_data  input  DATA_WIDTH*N*N  flat frame; element [i][j] at bits [(i*N+j)*DATA_WIDTH +: DATA_WIDTH].
- in_ready  output  1  high when a frame can be captured.
- out_valid  output  1  element valid.
- out_ready  input  1  consumer accepts element.
- out_data  output  DATA_WIDTH  current element.
- out_row  output  max(1,clog2(N))  row index i.
- out_col  output  max(1,clog2(N))  column index j.
- out_last_col  output  1  high when j == N-1.
- out_last  output  1  high when i == j == N-1.
- overrun  output  1  sticky: frame dropped.
- clr_overrun  input  1  clears overrun.
- frames_done  output  CNT_WIDTH  completed frames, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (async assert, any state):
  - state = IDLE, element index = 0, capture register = 0.
  - out_valid = 0, out_data = 0, out_row = out_col = 0, out_last_col = out_last = 0.
  - overrun = 0, frames_done = 0, in_ready = 1.
- States: IDLE and STREAM. in_ready = (state == IDLE), registered decode with no combinational path from any input.
- IDLE:
  - On in_valid && in_ready at edge T: capture in_data whole, set index = 0, go to STREAM.
  - out_valid rises after edge T (one-cycle capture latency).
- STREAM:
  - out_valid = 1.
  - out_data = captured element[index]; out_row = index / N; out_col = index % N.
  - out_last_col and out_last decode combinationally from the current index.
  - On out_valid && out_ready:
    - If index < N*N-1: index increments.
    - If index == N*N-1: return to IDLE and increment frames_done (wraps to 0).
  - Without a handshake, out_data and all tags hold stable. Backpressure may last any number of cycles.
- No same-cycle reload:
  - in_ready rises the cycle after the final handshake.
  - Minimum frame period is N*N+1 cycles at out_ready = 1.
- Overrun:
  - in_valid while in_ready = 0 sets overrun on the next edge; that frame is ignored.
  - The captured frame stays intact.
  - clr_overrun clears overrun. If clr_overrun and a new overrun event occur in the same cycle, set wins.
- in_valid is sampled only by level; a multi-cycle in_valid held into STREAM counts as overrun from the second cycle on.
  - Upstream must pulse result_valid for one cycle.
- ARRAY_SIZE = 1:
  - Index/row/col are 1 bit and stay 0.
  - out_last = out_last_col = 1 on the single element.
- Element values pass through unmodified; no saturation or rounding here.

Test Plan:
- Identity frame: rst, in_data = 64'h0400_0000_0000_0400, one-cycle in_valid, out_ready = 1.
  - Required: 4 elements in order 0x0400 (0,0), 0x0000 (0,1), 0x0000 (1,0), 0x0400 (1,1).
  - out_last_col on elements 2 and 4; out_last only on element 4.
  - frames_done = 1; in_ready high the cycle after element 4.
- Backpressure: in_data = 64'h0004_0003_0002_0001, out_ready toggled 1,0,0,1,0,1,1.
  - Required: out_data sequence 0x0001, 0x0002, 0x0003, 0x0004, each held stable with tags while out_ready = 0.
  - No element skipped or duplicated.
- Overrun: pulse in_valid with 64'hFFFF_FFFF_FFFF_FFFF while streaming frame 64'h0004_0003_0002_0001.
  - Required: overrun = 1 next cycle; streamed data remains 1,2,3,4; frames_done increments by 1 only.
  - Assert clr_overrun and a second illegal in_valid in the same cycle: overrun stays 1. clr_overrun alone: overrun drops to 0.
- Reset mid-stream: assert rst after 2 accepted elements.
  - Required: out_valid = 0, index = 0, frames_done = 0, in_ready = 1 immediately (async).
  - A new frame 64'h0400_0000_0000_0400 then streams from (0,0).
- Counter wrap: with CNT_WIDTH = 8, stream 257 frames back-to-back.
  - Required: frames_done reads 255 after frame 255, 0 after 256, 1 after 257.
  - Observed frame period is exactly 5 cycles at out_ready = 1.
